// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter for one shared 4:1 mux and the
// resource behind it. It issues registered one-hot grants and drives the
// mux select. Each grant is followed by one dead RELEASE cycle.
// Optional macro ARB_TIMEOUT_EN enables forced revoke after HOLD_MAX
// cycles, but only when another requester is waiting.
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] mux_ctrl,
  output logic       busy,
  output logic       revoke
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [1:0] r_mux, w_mux_nxt;
  logic [3:0] r_gnt, w_gnt_nxt;
  logic [7:0] w_req2;
  logic [3:0] w_rot;
  logic [1:0] w_off;
  logic [1:0] w_pick;
  logic       w_hold_req;
  logic       w_timeout;

  // Rotate the requests so that the bit at ptr lands at position 0.
  // The lowest set bit of the rotated vector is then the round-robin winner.
  assign w_req2     = {req, req} >> r_ptr;
  assign w_rot      = w_req2[3:0];
  assign w_pick     = r_ptr + w_off;
  assign w_hold_req = req[r_mux];

  // Priority-encode the rotated request vector.
  always_comb begin
    w_off = 2'd0;
    casez (w_rot)
      4'b???1: w_off = 2'd0;
      4'b??10: w_off = 2'd1;
      4'b?100: w_off = 2'd2;
      4'b1000: w_off = 2'd3;
      default: w_off = 2'd0;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_rev, w_rev_nxt;

  // A grant expires once it has been held HOLD_MAX cycles and someone else is waiting.
  assign w_timeout = (r_cnt >= CNT_W'(HOLD_MAX)) && ((req & ~r_gnt) != 4'b0000);

  // Hold counter and revoke pulse: the counter restarts at 1 on each new grant and saturates.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_rev_nxt = 1'b0;
    if (r_state == S_IDLE && req != 4'b0000)
      w_cnt_nxt = CNT_W'(1);
    else if (r_state == S_GRANT) begin
      if (w_hold_req && w_timeout)
        w_rev_nxt = 1'b1;
      else if (w_hold_req && r_cnt != {CNT_W{1'b1}})
        w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // Timeout bookkeeping registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_rev <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_rev <= w_rev_nxt;
    end
  end

  assign revoke = r_rev;
`else
  assign w_timeout = 1'b0;
  assign revoke    = 1'b0;
`endif

  // Next-state and grant logic. A grant starts from IDLE only.
  // It ends when the holder drops its request or when the timeout fires.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_mux_nxt   = r_mux;
    w_gnt_nxt   = r_gnt;
    case (r_state)
      S_IDLE: begin
        if (req != 4'b0000) begin
          w_gnt_nxt   = 4'b0001 << w_pick;
          w_mux_nxt   = w_pick;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!w_hold_req || w_timeout) begin
          w_gnt_nxt   = 4'b0000;
          w_ptr_nxt   = r_mux + 2'd1;
          w_state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // State, pointer, grant and mux-select registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd0;
      r_mux   <= 2'd0;
      r_gnt   <= 4'b0000;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_mux   <= w_mux_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  assign gnt      = r_gnt;
  assign mux_ctrl = r_mux;
  assign busy     = |r_gnt;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed steps plus random requests.
// A grant-lifecycle reference model supplies every expected output.
module tb_mux4_rr_arbiter;
  localparam int HM = 4;
  localparam int CW = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] mux_ctrl;
  logic       busy;
  logic       revoke;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.HOLD_MAX(HM), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .req(req), .gnt(gnt),
    .mux_ctrl(mux_ctrl), .busy(busy), .revoke(revoke)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who holds the resource, for how long, and remaining dead cycles.
  int m_holder = -1;
  int m_dead   = 0;
  int m_ptr    = 0;
  int m_cnt    = 0;
  int m_mux    = 0;
  bit m_rev    = 1'b0;

  int         order[$];
  logic [3:0] prev_gnt = 4'b0000;

  function automatic void model_reset();
    m_holder = -1; m_dead = 0; m_ptr = 0; m_cnt = 0; m_mux = 0; m_rev = 1'b0;
  endfunction

  function automatic void model_edge(input logic [3:0] r);
    m_rev = 1'b0;
    if (m_holder >= 0) begin
      if (!r[m_holder]) begin
        m_ptr = (m_holder + 1) % 4; m_holder = -1; m_dead = 1;
      end else if (TO && m_cnt >= HM && (r & ~(4'b0001 << m_holder)) != 4'b0000) begin
        m_ptr = (m_holder + 1) % 4; m_holder = -1; m_dead = 1; m_rev = 1'b1;
      end else if (m_cnt < (1 << CW) - 1) begin
        m_cnt++;
      end
    end else if (m_dead > 0) begin
      m_dead = 0;
    end else if (r != 4'b0000) begin
      for (int k = 0; k < 4; k++)
        if (r[(m_ptr + k) % 4]) begin m_holder = (m_ptr + k) % 4; break; end
      m_cnt = 1;
      m_mux = m_holder;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] eg;
    eg = (m_holder >= 0) ? (4'b0001 << m_holder) : 4'b0000;
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".mux"}, 32'(mux_ctrl), 32'(m_mux));
    chk({tag, ".busy"}, 32'(busy), 32'(eg != 4'b0000));
    chk({tag, ".revoke"}, 32'(revoke), 32'(m_rev));
  endtask

  // One clock: drive on the falling edge, update the model on the rising edge, sample 1ns later.
  task automatic cyc(input logic [3:0] r, input string tag);
    @(negedge clk);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check_all(tag);
    if (gnt != 4'b0000 && prev_gnt == 4'b0000)
      for (int i = 0; i < 4; i++) if (gnt[i]) order.push_back(i);
    prev_gnt = gnt;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    req  = 4'b0000;
    rstn = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    prev_gnt = 4'b0000;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    // Reset state
    #12;
    do_reset("reset");

    // 1: single requester 2 held for five cycles, then released
    for (int i = 0; i < 5; i++) cyc(4'b0100, "t1.hold");
    chk("t1.mux2", 32'(mux_ctrl), 32'd2);
    for (int i = 0; i < 3; i++) cyc(4'b0000, "t1.rel");

    // 2: fairness, each holder drops for one cycle after three granted cycles
    do_reset("t2.rst");
    order.delete();
    for (int i = 0; i < 40; i++) begin
      r = 4'b1111;
      if (m_holder >= 0 && m_cnt >= 3) r[m_holder] = 1'b0;
      cyc(r, "t2.rr");
    end
    chk("t2.nord", 32'(order.size() >= 5), 32'd1);
    if (order.size() >= 5) begin
      chk("t2.o0", 32'(order[0]), 32'd0);
      chk("t2.o1", 32'(order[1]), 32'd1);
      chk("t2.o2", 32'(order[2]), 32'd2);
      chk("t2.o3", 32'(order[3]), 32'd3);
      chk("t2.o4", 32'(order[4]), 32'd0);
    end

    // 3: pointer wrap after granting requester 3
    do_reset("t3.rst");
    cyc(4'b1000, "t3.g3");
    cyc(4'b0000, "t3.rel");
    cyc(4'b1001, "t3.dead");
    chk("t3.mux_hold", 32'(mux_ctrl), 32'd3);
    cyc(4'b1001, "t3.g0");
    chk("t3.gnt0", 32'(gnt), 32'b0001);
    chk("t3.mux0", 32'(mux_ctrl), 32'd0);
    cyc(4'b0000, "t3.end");
    cyc(4'b0000, "t3.end2");

    // 4: asynchronous reset in the middle of a grant
    cyc(4'b0010, "t4.g1");
    cyc(4'b0010, "t4.g1b");
    #2;
    rstn = 1'b0;
    #1;
    chk("t4.async_gnt", 32'(gnt), 32'd0);
    chk("t4.async_busy", 32'(busy), 32'd0);
    chk("t4.async_mux", 32'(mux_ctrl), 32'd0);
    model_reset();
    do_reset("t4.rst");
    cyc(4'b0011, "t4.first");
    chk("t4.gnt0", 32'(gnt), 32'b0001);
    cyc(4'b0000, "t4.rel");
    cyc(4'b0000, "t4.idle");

    // 5: single-cycle request
    cyc(4'b0010, "t5.g");
    cyc(4'b0000, "t5.rel");
    cyc(4'b0000, "t5.dead");
    cyc(4'b0000, "t5.idle");

    // 6a: long hold by requester 0 with requester 2 competing
    do_reset("t6.rst");
    cyc(4'b0001, "t6.g0");
    cyc(4'b0001, "t6.h");
    for (int i = 0; i < 12; i++) cyc(4'b0101, "t6.comp");
    cyc(4'b0000, "t6.off");
    cyc(4'b0000, "t6.off2");
    cyc(4'b0000, "t6.off3");
    // 6b: requester 0 alone never gets revoked
    for (int i = 0; i < 25; i++) cyc(4'b0001, "t6.alone");
    chk("t6.persist", 32'(gnt), 32'b0001);
    cyc(4'b0000, "t6.end");
    cyc(4'b0000, "t6.end2");

    // Random traffic: each request line toggles with probability 1/4 per cycle
    do_reset("rnd.rst");
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(3) == 0) r[b] = ~r[b];
      cyc(r, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
